serial_addsub: RTL and testbench

Bit-serial WIDTH-bit add/subtract unit built around a single full_adder1 instance and a carry flip-flop. It processes one bit per clock, LSB first. It is the sequential control stage that feeds full_adder1 its operand bits and carry, and consumes its sum/cout. It is the area-minimal arithmetic path for the 4-bit CPU datapath and hands a registered result plus flags to the register file / flag register.

---
 rtl/serial_addsub.sv | 167 ++++++++++++++++
 tb/tb_serial_addsub.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract unit: one full_adder1 plus a carry flip-flop,
// LSB first, with registered result and flags presented on a one-cycle done pulse.

module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    // Holds the WIDTH-1 sum bits already produced; the final bit joins them on the last step.
    logic [WIDTH-2:0]   res_sh_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   result_r;
    logic               cout_r;
    logic               zero_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

    logic               fa_sum_s;
    logic               fa_cout_s;
    logic               last_s;
    logic               load_s;
    logic [WIDTH-1:0]   shift_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;

    full_adder1 u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    assign last_s  = (cnt_r == CNT_LAST);
    assign load_s  = (state_r != S_RUN) && start;
    assign shift_s = {fa_sum_s, res_sh_r};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Status decode from the upcoming state, registered below
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (next_state_s)
            S_RUN:   busy_nxt_s = 1'b1;
            S_DONE:  done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Operand load, serial datapath step and result/flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {(WIDTH-1){1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= CNT_ZERO;
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (load_s) begin
                a_sh_r  <= a;
                b_sh_r  <= sub ? ~b : b;
                carry_r <= sub;
                cnt_r   <= CNT_ZERO;
            end else if (state_r == S_RUN) begin
                a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                res_sh_r <= shift_s[WIDTH-1:1];
                carry_r  <= fa_cout_s;
                cnt_r    <= cnt_r + CNT_ONE;
                if (last_s) begin
                    // carry_r is the carry into the MSB on this step
                    result_r <= shift_s;
                    cout_r   <= fa_cout_s;
                    ovf_r    <= carry_r ^ fa_cout_s;
                    zero_r   <= (shift_s == {WIDTH{1'b0}});
                end
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;
    assign zero   = zero_r;
    assign ovf    = ovf_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=4): vector table plus
// hand-written back-to-back, ignored-start and mid-operation reset sequences.

module tb_serial_addsub;
    logic       clk;
    logic       rst;
    logic       start;
    logic       sub;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       cout;
    logic       zero;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sub;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       c;
        logic       z;
        logic       o;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pulse start for one sampling edge; returns at the negedge right after the start edge.
    task automatic start_op(input logic s, input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the start edge; expects done on the 4th edge after it.
    task automatic wait_done(input string nm, input logic [3:0] er, input logic ec,
                             input logic ez, input logic eo, input bit glitch, input bit hold);
        int lat;
        lat = 0;
        check({nm, "_busy_start"}, busy, 1);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
            end else begin
                check({nm, "_busy_run"}, busy, 1);
                if (glitch && k == 2) begin
                    start = 1'b1;
                    sub   = 1'b0;
                    a     = 4'b0001;
                    b     = 4'b0001;
                end else if (!hold) begin
                    start = 1'b0;
                end
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
        end else begin
            check({nm, "_latency"}, lat, 4);
            check({nm, "_result"}, result, er);
            check({nm, "_cout"}, cout, ec);
            check({nm, "_zero"}, zero, ez);
            check({nm, "_ovf"}, ovf, eo);
            check({nm, "_busy_done"}, busy, 0);
        end
    endtask

    initial begin
        int done_cnt;
        //           sub   a        b        result   c     z     o
        vecs[0] = '{1'b0, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 4'b0111, 4'b0111, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 4'b0010, 4'b0101, 4'b1101, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 4'b0110, 4'b0111, 4'b1101, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 4'b1100, 4'b1100, 4'b1000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 4'b0011, 4'b1101, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = 4'b0000;
        b     = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_zero", zero, 0);
        check("rst_ovf", ovf, 0);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].sub, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].o, 1'b0, 1'b0);
        end

        // Back-to-back: start held through DONE, then a start pulse mid-run that must be ignored
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        a     = 4'b1111;
        b     = 4'b0001;
        @(negedge clk);
        wait_done("b2b_first", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        a = 4'b0011;
        b = 4'b0100;
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart_done", done, 0);
        wait_done("b2b_second", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_idle_busy", busy, 0);
        check("b2b_idle_done", done, 0);

        // Reset during the second RUN cycle aborts with no done pulse
        start_op(1'b0, 4'b0110, 4'b0001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_zero", zero, 0);
        check("abort_ovf", ovf, 0);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        start_op(1'b0, 4'b0001, 4'b0001);
        wait_done("after_abort", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
